// File: rtl/frame_buf_seq.sv
// Frame-buffer sequencer: captures one MAX_ROW x MAX_COL frame into a single-port
// BRAM, then drains it in raster order through a 2-entry fall-through output FIFO.
module frame_buf_seq #(
  parameter int MAX_ROW = 540,
  parameter int MAX_COL = 540,
  parameter int ADDR_W  = 19,
  parameter int RC_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [7:0]        pixel_i,
  input  logic              pixel_en_i,
  output logic              pixel_rdy_o,
  output logic              ena_o,
  output logic              wea_o,
  output logic [ADDR_W-1:0] addra_o,
  output logic [7:0]        d2mema_o,
  input  logic [7:0]        mem2da_i,
  output logic [7:0]        out_pixel_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [RC_W-1:0]   out_row_o,
  output logic [RC_W-1:0]   out_col_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int                N        = MAX_ROW * MAX_COL;
  localparam logic [ADDR_W-1:0] WR_LAST  = ADDR_W'(N - 1);
  localparam logic [ADDR_W:0]   RD_END   = (ADDR_W + 1)'(N);
  localparam logic [RC_W-1:0]   ROW_LAST = RC_W'(MAX_ROW - 1);
  localparam logic [RC_W-1:0]   COL_LAST = RC_W'(MAX_COL - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]   rd_addr_q, rd_addr_d;
  logic [RC_W-1:0]   row_q, row_d;
  logic [RC_W-1:0]   col_q, col_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              wptr_q, wptr_d;
  logic              rptr_q, rptr_d;
  logic [7:0]        fifo_q [2];

  logic       wr_fire, rd_fire, out_valid, pop, pop_fifo, push, last_tag;
  logic [2:0] occ_after;
  logic [7:0] head;

  assign wr_fire   = (state_q == S_FILL) && pixel_en_i;
  assign out_valid = (state_q == S_DRAIN) && ((cnt_q != 2'd0) || inflight_q);
  assign pop       = out_valid && out_ready_i;
  assign pop_fifo  = pop && (cnt_q != 2'd0);
  // Read data bypasses the FIFO when it is empty and is consumed the same cycle.
  assign push      = inflight_q && !(pop && (cnt_q == 2'd0));
  assign occ_after = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
  assign rd_fire   = (state_q == S_DRAIN) && (rd_addr_q < RD_END) && (occ_after <= 3'd1);
  assign last_tag  = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign head      = (cnt_q != 2'd0) ? fifo_q[rptr_q] : mem2da_i;

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    row_d      = row_q;
    col_d      = col_q;
    inflight_d = 1'b0;
    cnt_d      = cnt_q + 2'(push) - 2'(pop_fifo);
    wptr_d     = wptr_q ^ push;
    rptr_d     = rptr_q ^ pop_fifo;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_FILL;
          wr_addr_d = '0;
        end
      end
      S_FILL: begin
        if (wr_fire) begin
          wr_addr_d = wr_addr_q + 1'b1;
          if (wr_addr_q == WR_LAST) begin
            state_d   = S_DRAIN;
            rd_addr_d = '0;
            row_d     = '0;
            col_d     = '0;
          end
        end
      end
      S_DRAIN: begin
        inflight_d = rd_fire;
        if (rd_fire) rd_addr_d = rd_addr_q + 1'b1;
        if (pop) begin
          if (last_tag) begin
            state_d    = S_IDLE;
            row_d      = '0;
            col_d      = '0;
            inflight_d = 1'b0;
            cnt_d      = '0;
            wptr_d     = 1'b0;
            rptr_d     = 1'b0;
          end else if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      row_q      <= '0;
      col_q      <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      row_q      <= row_d;
      col_q      <= col_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // FIFO storage is data only; occupancy control above makes stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= mem2da_i;
  end

  always_comb begin
    addra_o = '0;
    if (state_q == S_FILL)       addra_o = wr_addr_q;
    else if (state_q == S_DRAIN) addra_o = rd_addr_q[ADDR_W-1:0];
  end

  assign ena_o        = wr_fire || rd_fire;
  assign wea_o        = wr_fire;
  assign d2mema_o     = wr_fire ? pixel_i : 8'd0;
  assign pixel_rdy_o  = (state_q == S_FILL);
  assign busy_o       = (state_q != S_IDLE);
  assign out_valid_o  = out_valid;
  assign out_pixel_o  = out_valid ? head : 8'd0;
  assign out_row_o    = row_q;
  assign out_col_o    = col_q;
  assign out_last_o   = out_valid && last_tag;
  assign frame_done_o = pop && last_tag;

endmodule

// File: doc/frame_buf_seq.md
# frame_buf_seq

Frame-buffer sequencer for the single-port 8-bit pixel BRAM. It fills one full MAX_ROW×MAX_COL frame from the incoming pixel stream, then drains the frame back out in raster order. Output uses a ready/valid stream tagged with row and column. It owns the BRAM port exclusively and sits between the camera/pixel source and the downstream processing engine.

## Interface
- MAX_ROW, 540, frame height in pixels
- MAX_COL, 540, frame width in pixels
- ADDR_W, 19, BRAM address width; must satisfy MAX_ROW*MAX_COL ≤ 2^ADDR_W
- RC_W, 10, row/column tag width; must hold MAX_ROW-1 and MAX_COL-1
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start_i  in  1  arm a frame capture; sampled only in IDLE
- pixel_i  in  8  input pixel
- pixel_en_i  in  1  input pixel valid
- pixel_rdy_o  out  1  input ready; a pixel transfers when pixel_en_i && pixel_rdy_o
- ena_o  out  1  BRAM enable
- wea_o  out  1  BRAM write enable (1 write, 0 read)
- addra_o  out  ADDR_W  BRAM address
- d2mema_o  out  8  BRAM write data
- mem2da_i  in  8  BRAM read data, valid 1 cycle after a read issue
- out_pixel_o  out  8  drained pixel
- out_valid_o  out  1  drained pixel valid
- out_ready_i  in  1  downstream ready; a pixel transfers when out_valid_o && out_ready_i
- out_row_o  out  RC_W  row of out_pixel_o
- out_col_o  out  RC_W  column of out_pixel_o
- out_last_o  out  1  high with the final pixel of the frame (row MAX_ROW-1, col MAX_COL-1)
- busy_o  out  1  state ≠ IDLE
- frame_done_o  out  1  one-cycle pulse when the last pixel transfers at the output

## Operation
- N = MAX_ROW*MAX_COL. FSM has three states: IDLE, FILL, DRAIN.
- IDLE:
  - pixel_rdy_o=0; pixel_en_i is ignored and the pixel dropped.
  - start_i=1 → FILL; write address is cleared to 0.
- FILL:
  - pixel_rdy_o=1.
  - Each transfer drives ena_o=1, wea_o=1, addra_o=wr_addr, d2mema_o=pixel_i in the same cycle, then increments wr_addr.
  - The transfer at wr_addr=N-1 moves the FSM → DRAIN; rd_addr, row and col are cleared.
- DRAIN:
  - pixel_rdy_o=0.
  - Reads go into a 2-entry output FIFO. A read is issued (ena_o=1, wea_o=0, addra_o=rd_addr) when rd_addr<N and fifo_count + inflight ≤ 1, counting the pop in the current cycle.
  - mem2da_i is pushed into the FIFO the cycle after issue.
  - The FIFO head drives out_pixel_o, out_valid_o, out_row_o, out_col_o and out_last_o.
  - On each output transfer, col increments; at MAX_COL-1 col wraps to 0 and row increments.
  - The transfer with out_last_o=1 pulses frame_done_o and moves the FSM → IDLE.
- In every state, when no access occurs: ena_o=0, wea_o=0, d2mema_o=0. addra_o holds the current counter (wr_addr in FILL, rd_addr in DRAIN, 0 in IDLE).
- start_i outside IDLE is ignored.
- The BRAM is never written and read in the same cycle.

## Timing
- Reset: state=IDLE. All outputs are 0: pixel_rdy_o, ena_o, wea_o, addra_o, d2mema_o, out_pixel_o, out_valid_o, out_row_o, out_col_o, out_last_o, busy_o, frame_done_o. Counters, FIFO and inflight are all cleared.
- Reset mid-FILL or mid-DRAIN aborts the frame. There are no output transfers after reset; BRAM contents are left as-is.
- start_i at cycle t → busy_o=1 and pixel_rdy_o=1 at t+1.
- Write latency is 0: the BRAM port is driven combinationally from the registered state/counter and pixel_i.
- The last write at cycle t → DRAIN at t+1, where the first read issues. mem2da_i is captured at t+2 and out_valid_o=1 at t+2.
- With out_ready_i held high, DRAIN sustains 1 pixel/cycle: N transfers over cycles t+2 … t+N+1. frame_done_o pulses at t+N+1, and busy_o=0 at t+N+2.
- Backpressure: with out_ready_i=0, out_valid_o and all tags hold stable. The FIFO fills to 2, then reads stall. No pixel is lost or duplicated.
- frame_done_o and out_last_o are high in the same cycle as the final transfer.

## Test plan
- Use MAX_ROW=4, MAX_COL=3 (N=12). Reset for 3 cycles → all outputs 0, busy_o=0; pixel_en_i pulses in IDLE produce no BRAM write.
- Pulse start_i, then stream pixels 0x10..0x1B continuously → 12 writes at addra 0..11 with wea_o=1. The FSM enters DRAIN after the write to addr 11, and pixel_rdy_o=0.
- Drain with out_ready_i=1 → outputs 0x10..0x1B on consecutive cycles with (row,col) (0,0)…(3,2). out_last_o and frame_done_o are both high on 0x1B, and busy_o falls the next cycle.
- Drain with random out_ready_i (about 50%) → identical ordered sequence. Values are stable while stalled, at most 2 reads outstanding+buffered, and no ena_o with wea_o=1 occurs in DRAIN.
- Pulse start_i during FILL and DRAIN → no effect. Assert rst_n=0 for 1 cycle after the 6th drained pixel → outputs 0 and IDLE; a new start_i plus 12 pixels runs a full frame correctly.
- Gapped input (pixel_en_i toggling) during FILL → writes occur only on transfer cycles, with addresses contiguous 0..11.
